neuron_mac_ctrl: RTL and testbench

//  Sequencer for the shared 8x8 signed multiplier `mult` in the digit-recognition datapath.
//  It computes one neuron: sum(x[i]*w[i]) over N_INPUTS pairs, plus bias, then shift, optional ReLU and saturation.

---
 rtl/nn_pkg.sv | 29 ++
 rtl/mac_out_stage.sv | 23 ++
 rtl/neuron_mac_ctrl.sv | 128 ++++++++++++
 tb/tb_neuron_mac_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath: controller states, the default data
// width and a signed saturation helper used wherever a wide sum is narrowed.
package nn_pkg;

  localparam int NN_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_BIAS,
    ST_OUT
  } mac_state_e;

  // Clamp a signed value into the range representable by a signed word of 'width' bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic signed [63:0] res;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    res   = value;
    if (value > max_v) res = max_v;
    if (value < min_v) res = min_v;
    return res;
  endfunction

endpackage

// File: rtl/mac_out_stage.sv
// Output conditioning for a finished neuron sum: arithmetic shift, optional ReLU,
// then saturation to the signed result width. Purely combinational.
module mac_out_stage
  import nn_pkg::*;
#(
  parameter int ACC_W  = 21,
  parameter int DATA_W = NN_DATA_W,
  parameter int SHIFT  = 0,
  parameter int RELU   = 1
) (
  input  logic signed [ACC_W-1:0]  acc_in,
  output logic signed [DATA_W-1:0] result_out
);

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc_in >>> SHIFT;
    if ((RELU != 0) && shifted[ACC_W-1]) shifted = '0;
    result_out = DATA_W'(sat_signed(64'(shifted), DATA_W));
  end

endmodule

// File: rtl/neuron_mac_ctrl.sv
// Sequencer for one neuron on a shared external multiplier: streams N_INPUTS x/w
// pairs through a two-stage read/multiply pipeline, adds bias and emits a saturated result.
module neuron_mac_ctrl
  import nn_pkg::*;
#(
  parameter int N_INPUTS = 16,
  parameter int DATA_W   = NN_DATA_W,
  parameter int ADDR_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
  parameter int ACC_W    = 2 * DATA_W + ADDR_W + 1,
  parameter int SHIFT    = 0,
  parameter int RELU     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [ACC_W-1:0]  bias,
  output logic                     busy,
  output logic                     done,
  output logic signed [DATA_W-1:0] result,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [DATA_W-1:0] x_data,
  input  logic signed [DATA_W-1:0] w_data,
  output logic signed [DATA_W-1:0] mult_a,
  output logic signed [DATA_W-1:0] mult_b,
  input  logic signed [2*DATA_W-1:0] mult_p
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);

  mac_state_e                state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      drain_q, drain_d;
  logic                      data_vld_q, data_vld_d;
  logic                      prod_vld_q, prod_vld_d;
  logic                      done_q, done_d;
  logic signed [2*DATA_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   bias_q, bias_d;
  logic signed [DATA_W-1:0]  result_q, result_d;
  logic signed [DATA_W-1:0]  out_val;
  logic                      accept;

  assign accept = (state_q == ST_IDLE) && start;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
        else                     addr_d  = addr_q + ADDR_W'(1);
      end
      // Two cycles let the final pair clear the memory read and product register.
      ST_DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) state_d = ST_BIAS;
      end
      ST_BIAS: state_d = ST_OUT;
      ST_OUT: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_vld_d = (state_q == ST_RUN);
    prod_vld_d = data_vld_q;
    prod_d     = data_vld_q ? mult_p : prod_q;
    bias_d     = accept ? bias : bias_q;
    acc_d      = acc_q;
    if (accept)                  acc_d = '0;
    else if (state_q == ST_BIAS) acc_d = acc_q + bias_q;
    else if (prod_vld_q)         acc_d = acc_q + ACC_W'(prod_q);
    done_d     = (state_q == ST_OUT);
    result_d   = (state_q == ST_OUT) ? out_val : result_q;
  end

  mac_out_stage #(
    .ACC_W (ACC_W),
    .DATA_W(DATA_W),
    .SHIFT (SHIFT),
    .RELU  (RELU)
  ) u_out_stage (
    .acc_in    (acc_q),
    .result_out(out_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      drain_q    <= 1'b0;
      data_vld_q <= 1'b0;
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      bias_q     <= '0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      drain_q    <= drain_d;
      data_vld_q <= data_vld_d;
      prod_vld_q <= prod_vld_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      bias_q     <= bias_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign result  = result_q;
  assign rd_addr = addr_q;
  assign mult_a  = x_data;
  assign mult_b  = w_data;

endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Directed bench for neuron_mac_ctrl: three N=4 instances (plain, ReLU, shift by 2)
// share stimulus, plus an N=1 instance for the single-pair boundary case.
module tb_neuron_mac_ctrl;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int ACCW  = 2 * DW + AW + 1;
  localparam int AW1   = 1;
  localparam int ACCW1 = 2 * DW + AW1 + 1;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic start_one;
  logic signed [ACCW-1:0]  bias;
  logic signed [ACCW1-1:0] bias_one;
  logic signed [DW-1:0]    x_mem [N];
  logic signed [DW-1:0]    w_mem [N];
  int total = 0;
  int bad   = 0;

  logic busy_a, done_a, busy_b, done_b, busy_c, done_c, busy_d, done_d;
  logic signed [DW-1:0] result_a, result_b, result_c, result_d;
  logic [AW-1:0]  rd_addr_a, rd_addr_b, rd_addr_c;
  logic [AW1-1:0] rd_addr_d;
  logic signed [DW-1:0] x_data_a, w_data_a, x_data_b, w_data_b;
  logic signed [DW-1:0] x_data_c, w_data_c, x_data_d, w_data_d;
  logic signed [DW-1:0] op_x_a, op_w_a, op_x_b, op_w_b, op_x_c, op_w_c, op_x_d, op_w_d;
  logic signed [2*DW-1:0] prod_a, prod_b, prod_c, prod_d;

  always #5 clk = ~clk;

  neuron_mac_ctrl #(.N_INPUTS(N), .DATA_W(DW), .SHIFT(0), .RELU(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .busy(busy_a), .done(done_a),
    .result(result_a), .rd_addr(rd_addr_a), .x_data(x_data_a), .w_data(w_data_a),
    .mult_a(op_x_a), .mult_b(op_w_a), .mult_p(prod_a));

  neuron_mac_ctrl #(.N_INPUTS(N), .DATA_W(DW), .SHIFT(0), .RELU(1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .busy(busy_b), .done(done_b),
    .result(result_b), .rd_addr(rd_addr_b), .x_data(x_data_b), .w_data(w_data_b),
    .mult_a(op_x_b), .mult_b(op_w_b), .mult_p(prod_b));

  neuron_mac_ctrl #(.N_INPUTS(N), .DATA_W(DW), .SHIFT(2), .RELU(0)) dut_c (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .busy(busy_c), .done(done_c),
    .result(result_c), .rd_addr(rd_addr_c), .x_data(x_data_c), .w_data(w_data_c),
    .mult_a(op_x_c), .mult_b(op_w_c), .mult_p(prod_c));

  neuron_mac_ctrl #(.N_INPUTS(1), .DATA_W(DW), .SHIFT(0), .RELU(0)) dut_d (
    .clk(clk), .rst(rst), .start(start_one), .bias(bias_one), .busy(busy_d), .done(done_d),
    .result(result_d), .rd_addr(rd_addr_d), .x_data(x_data_d), .w_data(w_data_d),
    .mult_a(op_x_d), .mult_b(op_w_d), .mult_p(prod_d));

  // External combinational multipliers and synchronous x/w memories, one per instance.
  assign prod_a = op_x_a * op_w_a;
  assign prod_b = op_x_b * op_w_b;
  assign prod_c = op_x_c * op_w_c;
  assign prod_d = op_x_d * op_w_d;

  always @(posedge clk) begin
    x_data_a <= x_mem[rd_addr_a];
    w_data_a <= w_mem[rd_addr_a];
    x_data_b <= x_mem[rd_addr_b];
    w_data_b <= w_mem[rd_addr_b];
    x_data_c <= x_mem[rd_addr_c];
    w_data_c <= w_mem[rd_addr_c];
    x_data_d <= x_mem[{1'b0, rd_addr_d}];
    w_data_d <= w_mem[{1'b0, rd_addr_d}];
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, $signed(observed), $signed(expected));
    end
  endtask

  // Byte i of xs/ws is element i of the x/w vectors.
  task automatic loadVectors(input logic [31:0] xs, input logic [31:0] ws);
    for (int i = 0; i < N; i++) begin
      x_mem[i] = xs[8*i +: 8];
      w_mem[i] = ws[8*i +: 8];
    end
  endtask

  // Raises start for one edge; returns in cycle 1 of the new run.
  task automatic applyStimulus(input logic [31:0] xs, input logic [31:0] ws, input int b);
    loadVectors(xs, ws);
    bias  = ACCW'(b);
    start = 1'b1;
    stepCycle();
    start = 1'b0;
  endtask

  // Walks cycles 1..N+5 of a run checking the handshake and address timeline,
  // then the three results in the done cycle. Optionally pulses start at cycle 3
  // (must be ignored) and at the done cycle (starts the next run).
  task automatic runNeuron(input string tag, input int exp_a, input int exp_b, input int exp_c,
                           input bit ghost, input bit chain);
    int exp_addr;
    for (int c = 1; c <= N + 5; c++) begin
      if (c > 1) stepCycle();
      start = (ghost && c == 3) || (chain && c == N + 5);
      exp_addr = (c <= N) ? c - 1 : ((c <= N + 4) ? N - 1 : 0);
      checkOutput($sformatf("%s busy c%0d", tag, c), busy_a, (c <= N + 4));
      checkOutput($sformatf("%s done c%0d", tag, c), done_a, (c == N + 5));
      checkOutput($sformatf("%s rd_addr c%0d", tag, c), rd_addr_a, exp_addr);
    end
    checkOutput($sformatf("%s result plain", tag), result_a, exp_a);
    checkOutput($sformatf("%s result relu", tag), result_b, exp_b);
    checkOutput($sformatf("%s result shift2", tag), result_c, exp_c);
    checkOutput($sformatf("%s done relu", tag), done_b, 1);
    checkOutput($sformatf("%s done shift2", tag), done_c, 1);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    start_one = 1'b0;
    bias      = '0;
    bias_one  = '0;
    loadVectors(32'h0, 32'h0);
    stepCycle();
    stepCycle();
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset busy", busy_a, 0);
    checkOutput("reset done", done_a, 0);
    checkOutput("reset result", result_a, 0);
    checkOutput("reset rd_addr", rd_addr_a, 0);
    checkOutput("reset result n1", result_d, 0);

    $display("[TB] sum 1..4");
    applyStimulus(32'h04030201, 32'h01010101, 0);
    runNeuron("sum", 10, 10, 2, 1'b0, 1'b0);

    $display("[TB] single negative product");
    applyStimulus(32'h000000FB, 32'h00000003, 0);
    runNeuron("neg", -15, 0, -4, 1'b0, 1'b0);

    $display("[TB] positive saturation");
    applyStimulus(32'h7F7F7F7F, 32'h7F7F7F7F, 0);
    runNeuron("satpos", 127, 127, 127, 1'b0, 1'b0);

    $display("[TB] negative saturation");
    applyStimulus(32'h80808080, 32'h7F7F7F7F, 0);
    runNeuron("satneg", -128, 0, -128, 1'b0, 1'b0);

    $display("[TB] bias and shift");
    applyStimulus(32'h02020202, 32'h04040404, -8);
    runNeuron("bias", 24, 24, 6, 1'b0, 1'b0);

    $display("[TB] handshake: ignored pulse then back-to-back run");
    applyStimulus(32'h04030201, 32'h01010101, 0);
    runNeuron("hs1", 10, 10, 2, 1'b1, 1'b1);
    stepCycle();
    start = 1'b0;
    runNeuron("hs2", 10, 10, 2, 1'b0, 1'b0);

    $display("[TB] reset during run");
    applyStimulus(32'h02020202, 32'h04040404, 0);
    stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    checkOutput("midrst busy", busy_a, 0);
    checkOutput("midrst done", done_a, 0);
    checkOutput("midrst result", result_a, 0);
    checkOutput("midrst rd_addr", rd_addr_a, 0);
    for (int c = 0; c < N + 4; c++) begin
      stepCycle();
      checkOutput($sformatf("midrst no done %0d", c), done_a, 0);
    end
    applyStimulus(32'h04030201, 32'h01010101, 0);
    runNeuron("postrst", 10, 10, 2, 1'b0, 1'b0);

    $display("[TB] single pair neuron");
    loadVectors(32'h000000FB, 32'h00000003);
    bias_one  = '0;
    start_one = 1'b1;
    stepCycle();
    start_one = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) stepCycle();
      checkOutput($sformatf("n1 busy c%0d", c), busy_d, (c <= 5));
      checkOutput($sformatf("n1 done c%0d", c), done_d, (c == 6));
      checkOutput($sformatf("n1 rd_addr c%0d", c), rd_addr_d, 0);
    end
    checkOutput("n1 result", result_d, -15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
